// File: rtl/interval_minmax_pkg.sv
// Shared constants and helpers for the interval min/max tracker.
package interval_minmax_pkg;

    localparam int DEFAULT_DATA_W = 16;

    // Most-positive signed value representable in w bits
    function automatic longint SMAX(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    // Most-negative signed value representable in w bits
    function automatic longint SMIN(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    // Width needed to hold values 0..n
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/minmax_lane.sv
// Per-channel running signed min/max accumulator for one window.
module minmax_lane
    import interval_minmax_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] i_sample,
    input  logic                     i_valid,
    input  logic                     i_first,
    input  logic                     i_clear,
    output logic signed [DATA_W-1:0] o_min_acc,
    output logic signed [DATA_W-1:0] o_max_acc
);

    localparam logic signed [DATA_W-1:0] MIN_INIT = DATA_W'(SMAX(DATA_W));
    localparam logic signed [DATA_W-1:0] MAX_INIT = DATA_W'(SMIN(DATA_W));

    logic signed [DATA_W-1:0] r_min_acc;
    logic signed [DATA_W-1:0] r_max_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_min_acc <= MIN_INIT;
            r_max_acc <= MAX_INIT;
        end else if (i_clear) begin
            r_min_acc <= MIN_INIT;
            r_max_acc <= MAX_INIT;
        end else if (i_valid) begin
            if (i_first) begin
                r_min_acc <= i_sample;
                r_max_acc <= i_sample;
            end else begin
                // strict compares: equal values leave the accumulator alone
                if (i_sample < r_min_acc) r_min_acc <= i_sample;
                if (i_sample > r_max_acc) r_max_acc <= i_sample;
            end
        end
    end

    assign o_min_acc = r_min_acc;
    assign o_max_acc = r_max_acc;

endmodule

// File: rtl/interval_minmax_tracker.sv
// Multi-channel windowed signed min/max tracker with valid/ready result stage.
// Optional PEAK_TO_PEAK_EN adds a registered per-channel max-min output (pp_out).
module interval_minmax_tracker
    import interval_minmax_pkg::*;
#(
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int CHANNELS     = 2,
    parameter int INTERVAL_LEN = 4410
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [CHANNELS*DATA_W-1:0]           audio_sample,
    input  logic                                 sample_valid,
    input  logic                                 clear,
    output logic [CHANNELS*DATA_W-1:0]           min_out,
    output logic [CHANNELS*DATA_W-1:0]           max_out,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 overrun,
`ifdef PEAK_TO_PEAK_EN
    output logic [CHANNELS*(DATA_W+1)-1:0]       pp_out,
`endif
    output logic [cnt_width(INTERVAL_LEN)-1:0]   frame_count
);

    localparam int CNT_W = cnt_width(INTERVAL_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INTERVAL_LEN - 1);

    logic [CNT_W-1:0]            r_cnt;
    logic [CHANNELS*DATA_W-1:0]  r_min_out;
    logic [CHANNELS*DATA_W-1:0]  r_max_out;
    logic                        r_out_valid;
    logic                        r_overrun;

    logic                        w_first;
    logic                        w_last;
    logic                        w_done;
    logic [CHANNELS*DATA_W-1:0]  w_min_fin;
    logic [CHANNELS*DATA_W-1:0]  w_max_fin;

    assign w_first = (r_cnt == '0);
    assign w_last  = (r_cnt == CNT_LAST);
    assign w_done  = sample_valid && w_last && !clear;

    // Window result includes the closing frame, so merge it combinationally
    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        logic signed [DATA_W-1:0] w_smp;
        logic signed [DATA_W-1:0] w_min_acc;
        logic signed [DATA_W-1:0] w_max_acc;

        assign w_smp = audio_sample[k*DATA_W +: DATA_W];

        minmax_lane #(.DATA_W(DATA_W)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .i_sample  (w_smp),
            .i_valid   (sample_valid),
            .i_first   (w_first),
            .i_clear   (clear),
            .o_min_acc (w_min_acc),
            .o_max_acc (w_max_acc)
        );

        assign w_min_fin[k*DATA_W +: DATA_W] =
            (w_first || (w_smp < w_min_acc)) ? w_smp : w_min_acc;
        assign w_max_fin[k*DATA_W +: DATA_W] =
            (w_first || (w_smp > w_max_acc)) ? w_smp : w_max_acc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= '0;
            r_min_out   <= '0;
            r_max_out   <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else if (clear) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (sample_valid)
                r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
            if (w_done) begin
                r_min_out   <= w_min_fin;
                r_max_out   <= w_max_fin;
                r_out_valid <= 1'b1;
                if (r_out_valid && !out_ready)
                    r_overrun <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef PEAK_TO_PEAK_EN
    logic [CHANNELS*(DATA_W+1)-1:0] w_pp_fin;
    logic [CHANNELS*(DATA_W+1)-1:0] r_pp_out;

    // Sign-extend by one bit so max-min can never wrap
    for (genvar k = 0; k < CHANNELS; k++) begin : g_pp
        logic [DATA_W:0] w_mx;
        logic [DATA_W:0] w_mn;
        assign w_mx = {w_max_fin[k*DATA_W + DATA_W - 1], w_max_fin[k*DATA_W +: DATA_W]};
        assign w_mn = {w_min_fin[k*DATA_W + DATA_W - 1], w_min_fin[k*DATA_W +: DATA_W]};
        assign w_pp_fin[k*(DATA_W+1) +: DATA_W+1] = w_mx - w_mn;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_pp_out <= '0;
        else if (w_done)
            r_pp_out <= w_pp_fin;
    end

    assign pp_out = r_pp_out;
`endif

    assign min_out     = r_min_out;
    assign max_out     = r_max_out;
    assign out_valid   = r_out_valid;
    assign overrun     = r_overrun;
    assign frame_count = r_cnt;

endmodule
